// File: rtl/sseg_pkg.sv
// Shared constants for the seven-segment display drivers: active-low glyphs
// (bit order gfedcba) and the converter FSM state encodings.
package sseg_pkg;

   localparam logic [6:0] SEG_0     = 7'b1000000;
   localparam logic [6:0] SEG_1     = 7'b1111001;
   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_4     = 7'b0011001;
   localparam logic [6:0] SEG_5     = 7'b0010010;
   localparam logic [6:0] SEG_6     = 7'b0000010;
   localparam logic [6:0] SEG_7     = 7'b1111000;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0010000;
   localparam logic [6:0] SEG_MINUS = 7'b0111111;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_SHIFT   = 2'd1;
   localparam logic [1:0] ST_COMPOSE = 2'd2;

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary to BCD engine; one bit per cycle, WIDTH cycles
// per conversion, with a sticky flag for digits lost off the top.
module bin2bcd_seq #(
   parameter int WIDTH  = 8,
   parameter int DIGITS = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [WIDTH-1:0]      mag_in,
   output logic                  last,
   output logic [4*DIGITS-1:0]   bcd,
   output logic                  ovf
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   logic [WIDTH-1:0]    mag;
   logic [CW-1:0]       cnt;
   logic                busy;
   logic [4*DIGITS-1:0] bcd_adj;

   always_comb begin
      bcd_adj = bcd;
      for (int i = 0; i < DIGITS; i++) begin
         if (bcd[4*i +: 4] >= 4'd5) begin
            bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
         end
      end
   end

   assign last = busy && (cnt == CW'(WIDTH - 1));

   // A 1 leaving the top nibble means the value needs more than DIGITS digits.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mag  <= '0;
         bcd  <= '0;
         ovf  <= 1'b0;
         cnt  <= '0;
         busy <= 1'b0;
      end else if (start) begin
         mag  <= mag_in;
         bcd  <= '0;
         ovf  <= 1'b0;
         cnt  <= '0;
         busy <= 1'b1;
      end else if (busy) begin
         {bcd, mag} <= {bcd_adj[4*DIGITS-2:0], mag, 1'b0};
         ovf        <= ovf | bcd_adj[4*DIGITS-1];
         cnt        <= cnt + CW'(1);
         if (last) begin
            busy <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/snum_sseg_driver.sv
// Multi-digit signed/unsigned seven-segment driver: load handshake, sequential
// BCD conversion, leading-zero blanking, floating minus and overflow display.
module snum_sseg_driver
   import sseg_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int DIGITS = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [WIDTH-1:0]      value,
   input  logic                  is_signed,
   input  logic                  load,
   input  logic                  enable,
   output logic                  ready,
   output logic                  done,
   output logic                  overflow,
   output logic [7*DIGITS-1:0]   segs
);

   logic [1:0]          state;
   logic                neg;
   logic [7*DIGITS-1:0] seg_reg;
   logic                start;
   logic                neg_in;
   logic [WIDTH-1:0]    mag_in;
   logic                last;
   logic                eng_ovf;
   logic [4*DIGITS-1:0] bcd;
   logic [7*DIGITS-1:0] seg_next;
   logic                ovf_next;
   int                  sig;

   function automatic logic [6:0] glyph(input logic [3:0] d);
      case (d)
         4'd0:    return SEG_0;
         4'd1:    return SEG_1;
         4'd2:    return SEG_2;
         4'd3:    return SEG_3;
         4'd4:    return SEG_4;
         4'd5:    return SEG_5;
         4'd6:    return SEG_6;
         4'd7:    return SEG_7;
         4'd8:    return SEG_8;
         4'd9:    return SEG_9;
         default: return SEG_BLANK;
      endcase
   endfunction

   assign ready  = (state == ST_IDLE);
   assign start  = load & ready;
   assign neg_in = is_signed & value[WIDTH-1];
   // Negating the most negative input wraps to 2^(WIDTH-1), which is the correct magnitude.
   assign mag_in = neg_in ? (~value + WIDTH'(1)) : value;

   bin2bcd_seq #(
      .WIDTH  (WIDTH),
      .DIGITS (DIGITS)
   ) u_bcd (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .mag_in (mag_in),
      .last   (last),
      .bcd    (bcd),
      .ovf    (eng_ovf)
   );

   // sig counts the significant digits; the minus sign floats just above them.
   always_comb begin
      sig = 1;
      for (int i = 0; i < DIGITS; i++) begin
         if (bcd[4*i +: 4] != 4'd0) begin
            sig = i + 1;
         end
      end
      ovf_next = eng_ovf | (neg && (sig == DIGITS));
      seg_next = '1;
      for (int i = 0; i < DIGITS; i++) begin
         if (ovf_next) begin
            seg_next[7*i +: 7] = SEG_MINUS;
         end else if (i < sig) begin
            seg_next[7*i +: 7] = glyph(bcd[4*i +: 4]);
         end else if ((i == sig) && neg) begin
            seg_next[7*i +: 7] = SEG_MINUS;
         end else begin
            seg_next[7*i +: 7] = SEG_BLANK;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         neg      <= 1'b0;
         seg_reg  <= '1;
         overflow <= 1'b0;
         done     <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  neg   <= neg_in;
                  state <= ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               if (last) begin
                  state <= ST_COMPOSE;
               end
            end
            ST_COMPOSE: begin
               seg_reg  <= seg_next;
               overflow <= ovf_next;
               done     <= 1'b1;
               state    <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign segs = enable ? seg_reg : '1;

endmodule

// File: tb/tb_snum_sseg_driver.sv
// Directed self-checking bench for snum_sseg_driver with a 4-digit and a
// 2-digit instance; expected segment patterns are hand-computed glyph strings.
module tb_snum_sseg_driver;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [7:0]  value, value2;
   logic        is_signed, is_signed2;
   logic        load, load2;
   logic        enable, enable2;
   logic        ready, ready2;
   logic        done, done2;
   logic        overflow, overflow2;
   logic [27:0] segs;
   logic [13:0] segs2;

   int checks = 0;
   int errors = 0;
   int cyc;
   int pulses;

   localparam logic [6:0] G0 = 7'h40, G1 = 7'h79, G2 = 7'h24, G4 = 7'h19;
   localparam logic [6:0] G5 = 7'h12, G8 = 7'h00, G9 = 7'h10;
   localparam logic [6:0] GM = 7'h3F, GB = 7'h7F;

   always #5 clk = ~clk;

   snum_sseg_driver #(.WIDTH(8), .DIGITS(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .value     (value),
      .is_signed (is_signed),
      .load      (load),
      .enable    (enable),
      .ready     (ready),
      .done      (done),
      .overflow  (overflow),
      .segs      (segs)
   );

   snum_sseg_driver #(.WIDTH(8), .DIGITS(2)) dut2 (
      .clk       (clk),
      .rst_n     (rst_n),
      .value     (value2),
      .is_signed (is_signed2),
      .load      (load2),
      .enable    (enable2),
      .ready     (ready2),
      .done      (done2),
      .overflow  (overflow2),
      .segs      (segs2)
   );

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input logic [7:0] v, input logic s);
      @(negedge clk);
      value     = v;
      is_signed = s;
      load      = 1'b1;
      @(negedge clk);
      load      = 1'b0;
   endtask

   task automatic applyStimulus2(input logic [7:0] v, input logic s);
      @(negedge clk);
      value2     = v;
      is_signed2 = s;
      load2      = 1'b1;
      @(negedge clk);
      load2      = 1'b0;
   endtask

   task automatic waitDone(output int c);
      c = -1;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         if (done) begin
            c = i;
            break;
         end
      end
   endtask

   task automatic waitDone2(output int c);
      c = -1;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         if (done2) begin
            c = i;
            break;
         end
      end
   endtask

   task automatic convert4(input string tag, input logic [7:0] v, input logic s,
                           input logic [27:0] exp_segs, input logic exp_ovf);
      int c;
      applyStimulus(v, s);
      checkOutput({tag, "_busy"}, 64'(ready), 64'd0);
      waitDone(c);
      checkOutput({tag, "_latency"}, 64'(c), 64'd9);
      checkOutput({tag, "_segs"}, 64'(segs), 64'(exp_segs));
      checkOutput({tag, "_ovf"}, 64'(overflow), 64'(exp_ovf));
      checkOutput({tag, "_ready_in_done"}, 64'(ready), 64'd1);
      @(negedge clk);
      checkOutput({tag, "_done_pulse"}, 64'(done), 64'd0);
   endtask

   task automatic convert2(input string tag, input logic [7:0] v, input logic s,
                           input logic [13:0] exp_segs, input logic exp_ovf);
      int c;
      applyStimulus2(v, s);
      waitDone2(c);
      checkOutput({tag, "_latency"}, 64'(c), 64'd9);
      checkOutput({tag, "_segs"}, 64'(segs2), 64'(exp_segs));
      checkOutput({tag, "_ovf"}, 64'(overflow2), 64'(exp_ovf));
   endtask

   initial begin
      rst_n      = 1'b0;
      value      = '0;
      is_signed  = 1'b0;
      load       = 1'b0;
      enable     = 1'b1;
      value2     = '0;
      is_signed2 = 1'b0;
      load2      = 1'b0;
      enable2    = 1'b1;
      repeat (2) @(negedge clk);
      checkOutput("reset_ready", 64'(ready), 64'd1);
      checkOutput("reset_done", 64'(done), 64'd0);
      checkOutput("reset_ovf", 64'(overflow), 64'd0);
      checkOutput("reset_segs", 64'(segs), 64'(28'hFFFFFFF));
      checkOutput("reset_segs2", 64'(segs2), 64'(14'h3FFF));
      rst_n = 1'b1;

      convert4("neg10", 8'hF6, 1'b1, {GB, GM, G1, G0}, 1'b0);
      convert4("u255",  8'hFF, 1'b0, {GB, G2, G5, G5}, 1'b0);
      convert4("neg1",  8'hFF, 1'b1, {GB, GB, GM, G1}, 1'b0);
      convert4("neg128", 8'h80, 1'b1, {GM, G1, G2, G8}, 1'b0);
      convert4("zero",  8'h00, 1'b1, {GB, GB, GB, G0}, 1'b0);

      convert2("d2_u255", 8'hFF, 1'b0, {GM, GM}, 1'b1);
      convert2("d2_neg9", 8'hF7, 1'b1, {GM, G9}, 1'b0);
      convert2("d2_neg10", 8'hF6, 1'b1, {GM, GM}, 1'b1);

      $display("[TB] ignored load during conversion");
      applyStimulus(8'd42, 1'b0);
      @(negedge clk);
      @(negedge clk);
      value = 8'd7;
      load  = 1'b1;
      @(negedge clk);
      load  = 1'b0;
      pulses = 0;
      for (int i = 0; i < 14; i++) begin
         @(negedge clk);
         if (done) pulses++;
      end
      checkOutput("ignored_load_pulses", 64'(pulses), 64'd1);
      checkOutput("ignored_load_segs", 64'(segs), 64'({GB, GB, G4, G2}));
      enable = 1'b0;
      #1;
      checkOutput("enable_off_segs", 64'(segs), 64'(28'hFFFFFFF));
      enable = 1'b1;
      #1;
      checkOutput("enable_on_segs", 64'(segs), 64'({GB, GB, G4, G2}));

      $display("[TB] reset during shift");
      applyStimulus(8'd99, 1'b0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      checkOutput("abort_ready", 64'(ready), 64'd1);
      checkOutput("abort_segs", 64'(segs), 64'(28'hFFFFFFF));
      checkOutput("abort_ovf", 64'(overflow), 64'd0);
      rst_n = 1'b1;
      pulses = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (done) pulses++;
      end
      checkOutput("abort_no_done", 64'(pulses), 64'd0);
      convert4("after_abort", 8'hFF, 1'b1, {GB, GB, GM, G1}, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/snum_sseg_driver.md
# snum_sseg_driver

Parametrised, multi-digit successor to the single-digit signed seven-segment converter. It accepts a WIDTH-bit two's-complement or unsigned value through a load/ready handshake and converts it to BCD sequentially (shift-add-3). It then drives DIGITS seven-segment digits with leading-zero blanking, a floating minus sign and overflow indication. It sits between the datapath result registers and the board display pins.

## Interface
- WIDTH, 8: input value width in bits (≥2).
- DIGITS, 4: number of seven-segment digits driven (≥1).
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- value  in  WIDTH  number to display; sampled only on an accepted load.
- is_signed  in  1  1: treat value as two's complement; 0: treat it as unsigned. Sampled with value.
- load  in  1  request conversion; accepted when load=1 and ready=1 at a rising edge.
- enable  in  1  display enable; 0 blanks all digits combinationally without affecting conversion.
- ready  out  1  high in IDLE only.
- done  out  1  one-cycle pulse when new segs/overflow are registered.
- overflow  out  1  last conversion did not fit in DIGITS digits.
- segs  out  7*DIGITS  active-low segments, per digit bit order gfedcba; digit 0 (rightmost, units) is segs[6:0].

## Operation
- Acceptance:
  - Latch sign: neg = is_signed & value[WIDTH-1].
  - Latch magnitude: mag = neg ? -value : value, as a WIDTH-bit unsigned value. The most negative input (e.g. -128) therefore gives magnitude 2^(WIDTH-1) correctly.
  - Clear the 4*DIGITS-bit BCD register and the sticky ovf flag.
- FSM states IDLE → SHIFT → COMPOSE → IDLE.
- IDLE: ready=1; an accepted load moves to SHIFT.
- SHIFT: WIDTH cycles, counted by a bit counter. Each cycle:
  - Add 3 to every BCD nibble ≥5.
  - Shift {bcd, mag} left by 1.
  - If the bit shifted out of the BCD MSB is 1, set ovf.
  - After the WIDTH-th shift, go to COMPOSE.
- COMPOSE: one cycle. Compute and register the display, assert done, return to IDLE.
  - sig = index of the most significant nonzero BCD digit + 1; sig = 1 for zero.
  - overflow = ovf | (neg & sig == DIGITS).
  - If overflow: every digit shows the minus pattern.
  - Otherwise:
    - Digits below sig show their decimal glyph.
    - Digit sig shows minus if neg, else blank.
    - Digits above that are blank.
- Zero always displays a single "0" with no minus.
- Output gating: segs = enable ? seg_reg : all ones. The registered content is retained while enable=0.
- A load while ready=0 is ignored; it is neither queued nor does it corrupt the conversion in progress.
- segs and overflow hold their previous values until the COMPOSE edge.

## Timing
- Reset values: state IDLE, ready=1, done=0, overflow=0, seg_reg all ones (blank), counter/BCD/mag cleared.
- rst_n=0 mid-conversion aborts it at the next edge. The display becomes blank, and no done pulse is produced for the aborted load.
- Load accepted at edge E0. Shifts occur at edges E1..E(WIDTH). seg_reg, overflow and done are updated at E(WIDTH+1).
- Latency is WIDTH+1 cycles from the accepting edge to done.
- ready is low from E0 through E(WIDTH+1), and high again in the cycle following E(WIDTH+1).
- A load asserted in the done cycle is accepted. Back-to-back throughput is one conversion per WIDTH+2 cycles.
- enable is a combinational path to segs, with no latency.

## Structure
- Shared package/header sseg_pkg:
  - Active-low glyph constants: SEG_0..SEG_9, SEG_MINUS = 7'b0111111, SEG_BLANK = 7'b1111111.
  - FSM state encodings.
- One sub-module, bin2bcd_seq: the sequential shift-add-3 engine (mag, bcd, counter, ovf) with a start/finish interface.
- The top level holds the FSM, the COMPOSE logic and the glyph lookup function.

## Test plan
All scenarios use WIDTH=8, DIGITS=4 unless stated.
- is_signed=1, value=8'hF6 (-10): done after 9 cycles, overflow=0, segs digits 3..0 = 7F, 3F, 79, 40 (" -10").
- is_signed=0, value=8'hFF: " 255", no minus. is_signed=1 with the same value gives "  -1" (7F, 7F, 3F, 79).
- value=8'h80, is_signed=1: "-128", overflow=0. value=0: "   0" (7F, 7F, 7F, 40).
- DIGITS=2:
  - Unsigned 255 → overflow=1, segs 3F, 3F.
  - Signed -9 → "-9", overflow=0.
  - Signed -10 → overflow=1.
- Load pulsed at cycle 3 of a conversion: ignored, only one done pulse, first result shown. Then enable=0 → segs all ones; enable=1 restores the result.
- rst_n low during SHIFT: next edge gives ready=1, segs blank, overflow=0, and no done pulse. A fresh load then converts correctly.
